brch_pred_unit: RTL and testbench
=================================

Name: brch_pred_unit

Overview:
- Parametrised successor to the branch-condition evaluator.
- Resolves conditional branches in EX; generalises to DW-bit operands and adds a PC-indexed table of 2-bit saturating counters (BHT) for IF-stage prediction.
- Detects mispredictions and drives redirect selection to the PC mux.
- Keeps saturating performance counters for resolved branches and mispredictions.

Parameters:
DW, 32, operand width of rs/rt
PCW, 32, program counter width
BHT_ENTRIES, 64, number of BHT entries (power of 2, >= 2)
CNT_W, 16, width of performance counters
BHT_INIT, 2'b01, reset value of every BHT entry (weakly not-taken)

Ports:
clk  in  1  system clock, all state rising-edge
rst  in  1  synchronous active-high reset
if_pc  in  PCW  fetch PC for prediction lookup
pred_taken  out  1  prediction for if_pc (counter MSB)
pc_write_cond  in  4  EX branch condition code (brch_defines encodings)
stall  in  1  EX stalled; suppresses resolution
rs  in  DW  first operand
rt  in  DW  second operand
ex_pc  in  PCW  PC of the branch in EX
ex_pred  in  1  prediction carried down the pipe with the branch
brch  out  1  actual branch outcome
mispredict  out  1  resolved outcome differs from ex_pred
redirect_sel  out  2  0 none, 1 branch target, 2 fall-through (ex_pc+4)
br_cnt  out  CNT_W  resolved-branch count
mp_cnt  out  CNT_W  misprediction count

Behaviour:
- Index: idx = pc[2 +: log2(BHT_ENTRIES)]; word-aligned, bits [1:0] ignored.
- Lookup is combinational from flop array: pred_taken = bht[idx(if_pc)][1].
- resolve = !stall && pc_write_cond != COND_NONE.
- Outcome, combinational, DW-generic (zero means rs == 0, neg means rs[DW-1]):
  - BEQ: rs == rt
  - BNQ: rs != rt
  - BGEZ: !neg
  - BGTZ: !neg && !zero
  - BLEZ: neg || zero
  - BLTZ: neg
  - Any other code, or !resolve: brch = 0.
- mispredict = resolve && (brch != ex_pred).
- redirect_sel = mispredict ? (brch ? 1 : 2) : 0. Same cycle, zero latency.
- BHT update on the clk edge when resolve:
  - brch = 1: counter increments, saturating at 11.
  - brch = 0: counter decrements, saturating at 00.
  - Non-resolving cycles leave the BHT unchanged.
- Same-index lookup and update in one cycle: pred_taken reflects the pre-update value (no bypass); the new value is visible next cycle.
- Perf counters:
  - br_cnt increments when resolve.
  - mp_cnt increments when mispredict.
  - Both saturate at all-ones; no wrap.
- Reset, one cycle, synchronous:
  - All BHT entries = BHT_INIT; br_cnt = mp_cnt = 0.
  - Combinational outputs follow inputs.
  - With all entries at BHT_INIT, pred_taken = 0 after reset.
- rst asserted together with resolve: reset wins; no update, no count.
- rst has no gating effect on combinational brch/mispredict. The pipeline's own flush covers that cycle.
- stall high: brch = mispredict = 0, redirect_sel = 0, no state change (branch re-resolves when released).
- Undefined cond codes behave as COND_NONE.

Decomposition:
- Shared define file brch_defines holds the cond codes:
  - COND_NONE = 4'h0, COND_BEQ = 4'h1, COND_BNQ = 4'h2, COND_BGEZ = 4'h3, COND_BGTZ = 4'h4, COND_BLEZ = 4'h5, COND_BLTZ = 4'h6.
  - It also holds the redirect_sel codes RSEL_NONE/RSEL_TGT/RSEL_FALL (0/1/2).
- One natural sub-module: brch_cond_eval.
  - Purely combinational; parameter DW.
  - Inputs: pc_write_cond, stall, rs, rt. Output: brch.
- BHT array, update logic and perf counters stay in brch_pred_unit.

Test Plan:
1. Reset then if_pc = 0x0000_0040 -> pred_taken = 0, br_cnt = mp_cnt = 0.
2. BEQ, rs = rt = 0x1234, ex_pred = 0, ex_pc = 0x40, three consecutive cycles:
   - Each cycle: brch = 1, mispredict = 1, redirect_sel = 1.
   - After the first cycle, pred_taken for 0x40 = 1; counter ends at 11 (saturated).
   - br_cnt = mp_cnt = 3.
3. BGTZ with rs = 0 -> brch = 0. BGTZ with rs = 0x8000_0000 -> brch = 0. BLEZ with rs = 0 -> brch = 1. Repeat with DW = 16 and rs = 0x8000 -> BLTZ brch = 1.
4. stall = 1 with BNQ, rs = 1, rt = 2, ex_pred = 0:
   - brch = 0, redirect_sel = 0, counters and BHT unchanged.
   - Release stall -> brch = 1, mispredict = 1.
5. Same idx on if_pc and ex_pc (0x80 and 0x80+4·BHT_ENTRIES), entry at 01, resolve taken -> pred_taken = 0 that cycle, 1 the next.
6. Preload br_cnt to all-ones (drive 2^CNT_W resolves at CNT_W = 4) -> stays 0xF. Assert rst during a resolve -> counts 0, BHT = BHT_INIT.

Source files
------------

// File: rtl/brch_pred_unit_pkg.sv
// brch_pred_unit_pkg: branch condition codes, redirect codes and 2-bit counter helpers
package brch_pred_unit_pkg;
  typedef enum logic [3:0] {
    COND_NONE = 4'h0,
    COND_BEQ  = 4'h1,
    COND_BNQ  = 4'h2,
    COND_BGEZ = 4'h3,
    COND_BGTZ = 4'h4,
    COND_BLEZ = 4'h5,
    COND_BLTZ = 4'h6
  } cond_e;
  typedef enum logic [1:0] {
    RSEL_NONE = 2'd0,
    RSEL_TGT  = 2'd1,
    RSEL_FALL = 2'd2
  } rsel_e;
  function automatic logic cond_valid(input logic [3:0] c);
    return c >= COND_BEQ && c <= COND_BLTZ;
  endfunction
  function automatic logic [1:0] ctr_next(input logic [1:0] c, input logic taken);
    return taken ? ((c == 2'b11) ? c : c + 2'd1) : ((c == 2'b00) ? c : c - 2'd1);
  endfunction
endpackage

// File: rtl/brch_cond_eval.sv
// brch_cond_eval: combinational DW-bit branch outcome evaluation
module brch_cond_eval
  import brch_pred_unit_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic [3:0]    pc_write_cond,
  input  logic          stall,
  input  logic [DW-1:0] rs,
  input  logic [DW-1:0] rt,
  output logic          brch
);
  logic neg, zero;
  assign neg  = rs[DW-1];
  assign zero = ~|rs;
  always_comb begin
    case (cond_e'(pc_write_cond))
      COND_BEQ:  brch = rs == rt;
      COND_BNQ:  brch = rs != rt;
      COND_BGEZ: brch = !neg;
      COND_BGTZ: brch = !neg && !zero;
      COND_BLEZ: brch = neg || zero;
      COND_BLTZ: brch = neg;
      default:   brch = 1'b0;
    endcase
    if (stall) brch = 1'b0;
  end
endmodule

// File: rtl/brch_pred_unit.sv
// brch_pred_unit: EX branch resolution, BHT prediction, mispredict redirect and perf counters
module brch_pred_unit
  import brch_pred_unit_pkg::*;
#(
  parameter int         DW          = 32,
  parameter int         PCW         = 32,
  parameter int         BHT_ENTRIES = 64,
  parameter int         CNT_W       = 16,
  parameter logic [1:0] BHT_INIT    = 2'b01
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PCW-1:0]   if_pc,
  output logic             pred_taken,
  input  logic [3:0]       pc_write_cond,
  input  logic             stall,
  input  logic [DW-1:0]    rs,
  input  logic [DW-1:0]    rt,
  input  logic [PCW-1:0]   ex_pc,
  input  logic             ex_pred,
  output logic             brch,
  output logic             mispredict,
  output logic [1:0]       redirect_sel,
  output logic [CNT_W-1:0] br_cnt,
  output logic [CNT_W-1:0] mp_cnt
);
  localparam int IW = $clog2(BHT_ENTRIES);
  logic [1:0]       bht_q [BHT_ENTRIES];
  logic [1:0]       bht_d [BHT_ENTRIES];
  logic [CNT_W-1:0] br_cnt_q, br_cnt_d, mp_cnt_q, mp_cnt_d;
  logic [IW-1:0]    if_idx, ex_idx;
  logic             resolve, unused_pc;
  brch_cond_eval #(.DW(DW)) u_eval (
    .pc_write_cond(pc_write_cond),
    .stall        (stall),
    .rs           (rs),
    .rt           (rt),
    .brch         (brch)
  );
  assign resolve      = !stall && cond_valid(pc_write_cond);
  assign if_idx       = if_pc[2 +: IW];
  assign ex_idx       = ex_pc[2 +: IW];
  assign unused_pc    = ^{if_pc, ex_pc};
  // Read straight from the flops: a same-cycle update is not bypassed
  assign pred_taken   = bht_q[if_idx][1];
  assign mispredict   = resolve && (brch != ex_pred);
  assign redirect_sel = mispredict ? (brch ? RSEL_TGT : RSEL_FALL) : RSEL_NONE;
  assign br_cnt       = br_cnt_q;
  assign mp_cnt       = mp_cnt_q;
  always_comb begin
    bht_d = bht_q;
    if (resolve) bht_d[ex_idx] = ctr_next(bht_q[ex_idx], brch);
    br_cnt_d = (resolve && ~&br_cnt_q) ? br_cnt_q + 1'b1 : br_cnt_q;
    mp_cnt_d = (mispredict && ~&mp_cnt_q) ? mp_cnt_q + 1'b1 : mp_cnt_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      bht_q    <= '{default: BHT_INIT};
      br_cnt_q <= '0;
      mp_cnt_q <= '0;
    end else begin
      bht_q    <= bht_d;
      br_cnt_q <= br_cnt_d;
      mp_cnt_q <= mp_cnt_d;
    end
  end
endmodule

// File: tb/tb_brch_pred_unit.sv
// tb_brch_pred_unit: directed stimulus with a queue-based scoreboard checked on the falling edge
module tb_brch_pred_unit;
  logic        clk, rst, stall, ex_pred;
  logic [31:0] if_pc, ex_pc, rs, rt;
  logic [3:0]  cond;
  logic        pred_taken, brch, mispredict;
  logic [1:0]  redirect_sel;
  logic [3:0]  br_cnt, mp_cnt;
  logic        d16_pred, d16_brch, d16_mp;
  logic [1:0]  d16_rsel;
  logic [15:0] d16_br, d16_mpc;

  typedef struct {
    string      nm;
    logic       brch, mp;
    logic [1:0] rsel;
    logic       pred;
    logic [3:0] br, mpc;
    logic       b16;
    logic [1:0] en;
  } exp_t;
  exp_t q[$];
  int n_cmp = 0, n_bad = 0;

  brch_pred_unit #(.DW(32), .PCW(32), .BHT_ENTRIES(64), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .if_pc(if_pc), .pred_taken(pred_taken),
    .pc_write_cond(cond), .stall(stall), .rs(rs), .rt(rt), .ex_pc(ex_pc),
    .ex_pred(ex_pred), .brch(brch), .mispredict(mispredict),
    .redirect_sel(redirect_sel), .br_cnt(br_cnt), .mp_cnt(mp_cnt)
  );
  brch_pred_unit #(.DW(16), .PCW(32), .BHT_ENTRIES(64), .CNT_W(16)) dut16 (
    .clk(clk), .rst(rst), .if_pc(if_pc), .pred_taken(d16_pred),
    .pc_write_cond(cond), .stall(stall), .rs(rs[15:0]), .rt(rt[15:0]), .ex_pc(ex_pc),
    .ex_pred(ex_pred), .brch(d16_brch), .mispredict(d16_mp),
    .redirect_sel(d16_rsel), .br_cnt(d16_br), .mp_cnt(d16_mpc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string nm, input string f, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s.%s: got %0h expected %0h", nm, f, act, exp);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        e = q.pop_front();
        cmp(e.nm, "brch", 32'(brch), 32'(e.brch));
        cmp(e.nm, "mispredict", 32'(mispredict), 32'(e.mp));
        cmp(e.nm, "redirect_sel", 32'(redirect_sel), 32'(e.rsel));
        cmp(e.nm, "br_cnt", 32'(br_cnt), 32'(e.br));
        cmp(e.nm, "mp_cnt", 32'(mp_cnt), 32'(e.mpc));
        if (e.en[0]) cmp(e.nm, "pred_taken", 32'(pred_taken), 32'(e.pred));
        if (e.en[1]) cmp(e.nm, "brch_dw16", 32'(d16_brch), 32'(e.b16));
      end
    end
  end

  task automatic step(input string nm, input logic r, input logic [3:0] c, input logic st,
                      input logic [31:0] a, input logic [31:0] b, input logic [31:0] xpc,
                      input logic xp, input logic [31:0] ipc,
                      input logic eb, input logic em, input logic [1:0] ers, input logic ep,
                      input logic [3:0] ebr, input logic [3:0] emp, input logic eb16,
                      input logic [1:0] en);
    exp_t e;
    rst = r; cond = c; stall = st; rs = a; rt = b; ex_pc = xpc; ex_pred = xp; if_pc = ipc;
    e.nm = nm; e.brch = eb; e.mp = em; e.rsel = ers; e.pred = ep;
    e.br = ebr; e.mpc = emp; e.b16 = eb16; e.en = en;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] sat15(input int v);
    return (v > 15) ? 4'd15 : 4'(v);
  endfunction

  initial begin
    rst = 1'b1; cond = 4'h0; stall = 1'b0; rs = '0; rt = '0;
    ex_pc = '0; ex_pred = 1'b0; if_pc = '0;
    @(posedge clk);
    #1;
    step("reset_state", 0, 4'h0, 0, 0, 0, 0, 0, 32'h40,        0, 0, 2'd0, 0, 4'd0, 4'd0, 0, 2'b11);
    step("beq1",        0, 4'h1, 0, 32'h1234, 32'h1234, 32'h40, 0, 32'h40, 1, 1, 2'd1, 0, 4'd0, 4'd0, 1, 2'b11);
    step("beq2",        0, 4'h1, 0, 32'h1234, 32'h1234, 32'h40, 0, 32'h40, 1, 1, 2'd1, 1, 4'd1, 4'd1, 1, 2'b11);
    step("beq3",        0, 4'h1, 0, 32'h1234, 32'h1234, 32'h40, 0, 32'h40, 1, 1, 2'd1, 1, 4'd2, 4'd2, 1, 2'b11);
    step("beq_after",   0, 4'h0, 0, 0, 0, 32'h40, 0, 32'h40,          0, 0, 2'd0, 1, 4'd3, 4'd3, 0, 2'b11);
    step("bgtz_zero",   0, 4'h4, 0, 0, 0, 32'h100, 0, 32'h40,         0, 0, 2'd0, 1, 4'd3, 4'd3, 0, 2'b11);
    step("bgtz_neg",    0, 4'h4, 0, 32'h8000_0000, 0, 32'h100, 0, 32'h40, 0, 0, 2'd0, 1, 4'd4, 4'd3, 0, 2'b11);
    step("blez_zero",   0, 4'h5, 0, 0, 0, 32'h100, 0, 32'h40,         1, 1, 2'd1, 1, 4'd5, 4'd3, 1, 2'b11);
    step("bltz_dw16",   0, 4'h6, 0, 32'h8000, 0, 32'h100, 0, 32'h40,  0, 0, 2'd0, 1, 4'd6, 4'd4, 1, 2'b11);
    step("stall1",      0, 4'h2, 1, 1, 2, 32'h100, 0, 32'h40,         0, 0, 2'd0, 1, 4'd7, 4'd4, 0, 2'b11);
    step("stall2",      0, 4'h2, 1, 1, 2, 32'h100, 0, 32'h40,         0, 0, 2'd0, 1, 4'd7, 4'd4, 0, 2'b11);
    step("bnq_release", 0, 4'h2, 0, 1, 2, 32'h100, 0, 32'h40,         1, 1, 2'd1, 1, 4'd7, 4'd4, 1, 2'b11);
    step("beq_fall",    0, 4'h1, 0, 1, 2, 32'h100, 1, 32'h40,         0, 1, 2'd2, 1, 4'd8, 4'd5, 0, 2'b11);
    step("bnq_correct", 0, 4'h2, 0, 5, 6, 32'h100, 1, 32'h40,         1, 0, 2'd0, 1, 4'd9, 4'd6, 1, 2'b11);
    step("alias_same",  0, 4'h1, 0, 7, 7, 32'h180, 1, 32'h80,         1, 0, 2'd0, 0, 4'd10, 4'd6, 1, 2'b11);
    step("alias_next",  0, 4'h0, 0, 0, 0, 32'h180, 1, 32'h80,         0, 0, 2'd0, 1, 4'd11, 4'd6, 0, 2'b11);
    for (int i = 0; i < 6; i++)
      step("br_sat",    0, 4'h1, 0, 0, 0, 32'h200, 1, 32'h40,         1, 0, 2'd0, 1, sat15(11 + i), 4'd6, 1, 2'b11);
    for (int i = 0; i < 11; i++)
      step("mp_sat",    0, 4'h1, 0, 0, 0, 32'h40, 0, 32'h40,          1, 1, 2'd1, 1, 4'd15, sat15(6 + i), 1, 2'b11);
    step("rst_resolve", 1, 4'h1, 0, 0, 0, 32'h80, 0, 32'h80,          1, 1, 2'd1, 1, 4'd15, 4'd15, 1, 2'b11);
    step("post_rst_a",  0, 4'h0, 0, 0, 0, 32'h80, 0, 32'h80,          0, 0, 2'd0, 0, 4'd0, 4'd0, 0, 2'b11);
    step("post_rst_b",  0, 4'h0, 0, 0, 0, 32'h80, 0, 32'h40,          0, 0, 2'd0, 0, 4'd0, 4'd0, 0, 2'b11);
    for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
    if (q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d entries left, required 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
